fb_fill_writer: RTL and testbench
=================================

# fb_fill_writer

Writes one full frame of 8-bit palette indices into the SDRAM frame buffer, one word per address, using a write/waitrequest handshake toward the SDRAM controller. It is the producer side of the frame buffer that the VGA scan-out path reads. It asserts `done` once the whole frame is committed, which is the condition the scan-out path waits on before it starts reading. Content comes from a selectable built-in test pattern, so the display path can be brought up without a host.

## Interface
- `ADDR_W`, 25, SDRAM word-address width
- `DATA_W`, 16, SDRAM data width; index occupies bits [7:0], upper bits driven 0
- `FRAME_W`, 320, pixels per line
- `FRAME_H`, 240, lines per frame (FRAME_W*FRAME_H = 76800 words)
- `SOLID_INDEX`, 8'hb9, index used by the solid pattern

Ports:
- `sdram_clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a frame fill (level sampled each cycle)
- `pattern_sel`  in  2  pattern for the next fill: 0 bars, 1 ramp, 2 solid, 3 checker
- `waitrequest`  in  1  SDRAM controller stall; write not accepted while high
- `write`  out  1  write request
- `oAddress`  out  ADDR_W  word address of the current write
- `writedata`  out  DATA_W  data of the current write
- `busy`  out  1  fill in progress
- `done`  out  1  full frame committed
- `frame_count`  out  8  completed fills, wraps 255→0

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - On `start`=1, latch `pattern_sel` and clear x, y and address to 0.
  - Drive `write`=1 and `busy`=1, then go to WRITE.
- WRITE:
  - A beat is accepted on an edge where `write`=1 and `waitrequest`=0.
  - On accept, increment the address.
  - Increment x; on x=FRAME_W-1, wrap x to 0 and increment y.
  - Keep `write`=1 for back-to-back beats.
  - While `waitrequest`=1, hold address, data and `write` stable.
- Last beat: the accept at x=FRAME_W-1, y=FRAME_H-1 (address 76799) does the following:
  - drop `write`;
  - set `done`=1 and `busy`=0;
  - increment `frame_count`;
  - go to DONE.
- DONE:
  - `done` holds at 1.
  - `start`=1 clears `done` and begins a new fill exactly as in IDLE.
- `start` while in WRITE is ignored.
- A `pattern_sel` change mid-fill has no effect; the latched value is used for the whole frame.
- Patterns, as a function of x and y (data = {8'h00, index}):
  - bars: x<107 → 8'hff; 107≤x<214 → 8'ha0; else 8'h6c.
  - ramp: address[7:0].
  - solid: SOLID_INDEX.
  - checker: x[4]^y[4] ? 8'hff : 8'h00.
- Address arithmetic is ADDR_W wide and zero-extended from the 17-bit frame count. It never exceeds FRAME_W*FRAME_H-1.

## Timing
- Reset values: `write`=0, `oAddress`=0, `writedata`=0, `busy`=0, `done`=0, `frame_count`=0, state IDLE.
- `start` is sampled at edge N. At edge N+1, `write`=1, `oAddress`=0 and data for (0,0) are presented. Start-to-first-request latency is 1 cycle.
- Throughput: 1 word/cycle with no stall. A full fill takes 76800 + stall cycles.
- `writedata` is registered and always corresponds to the current `oAddress`. It updates on the same edge as the address.
- `done` rises on the edge after the last accept, together with `write` falling.
- `rst` in any state returns all outputs to their reset values on that edge. A partial frame is abandoned.
- Simultaneous `rst` and `start`: reset wins.

## Configuration
- `FB_FILL_CHECKER_EN`:
  - Defined: pattern 3 produces the checkerboard.
  - Undefined: the checker logic is omitted and pattern 3 behaves identically to pattern 2 (solid).

## Test plan
- Reset, then `start` 1-cycle pulse with sel=2 and `waitrequest`=0:
  - `write` high for exactly 76800 cycles;
  - addresses 0..76799 consecutive, all data 16'h00b9;
  - `done`=1 the next cycle, `frame_count`=1.
- sel=0, no stall: data 16'h00ff at address 106, 16'h00a0 at address 107, 16'h006c at address 214, 16'h00ff at address 320.
- sel=1 with `waitrequest` high for 3 cycles at address 5:
  - address 5 and data 16'h0005 held for 4 cycles;
  - no address skipped or repeated;
  - `done` asserted after 76803 write cycles.
- `rst` pulsed at address 1000:
  - next cycle `write`=0, `oAddress`=0, `busy`=0, `done`=0;
  - a new `start` restarts at address 0.
- Second `start` while in WRITE: no effect. `start` in DONE: `done` clears, refill runs, `frame_count`=2.
- sel=3: data 16'h0000 at address 0, 16'h00ff at address 16, 16'h00ff at address 5120 (y=16).
  - With `FB_FILL_CHECKER_EN` undefined, every word is 16'h00b9.

Source files
------------

// File: rtl/fb_fill_writer.sv
// fb_fill_writer: fills one frame of palette indices into SDRAM.
// Build option: FB_FILL_CHECKER_EN enables the checkerboard pattern.
module fb_fill_writer #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16,
    parameter int FRAME_W = 320,
    parameter int FRAME_H = 240,
    parameter logic [7:0] SOLID_INDEX = 8'hb9
) (
    input  logic              sdram_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    input  logic              waitrequest,
    output logic              write,
    output logic [ADDR_W-1:0] oAddress,
    output logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_count
);

    localparam int XW = $clog2(FRAME_W);
    localparam int YW = $clog2(FRAME_H);

    localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
    localparam logic [XW-1:0] BAR1 = XW'(107);
    localparam logic [XW-1:0] BAR2 = XW'(214);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]        sel_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;

    logic              accept;
    logic              last_beat;
    logic              launch;

    logic [1:0]        sel_nx;
    logic [XW-1:0]     x_nx;
    logic [YW-1:0]     y_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [7:0]        index_nx;

    assign accept    = write & ~waitrequest;
    assign last_beat = accept & (x_q == X_LAST) & (y_q == Y_LAST);
    // A fill can only be launched while no fill is running.
    assign launch    = start & (state != WRITE);

    // State register; reset abandons any partial frame.
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (last_beat) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nx = WRITE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Next pixel position: origin on launch, advance on accept, else hold.
    always_comb begin
        sel_nx  = sel_q;
        x_nx    = x_q;
        y_nx    = y_q;
        addr_nx = oAddress;
        if (launch) begin
            sel_nx  = pattern_sel;
            x_nx    = '0;
            y_nx    = '0;
            addr_nx = '0;
        end else if (accept) begin
            addr_nx = oAddress + ADDR_W'(1);
            if (x_q == X_LAST) begin
                x_nx = '0;
                y_nx = y_q + YW'(1);
            end else begin
                x_nx = x_q + XW'(1);
            end
        end
    end

    // Pattern generator for the next presented pixel.
    always_comb begin
        index_nx = SOLID_INDEX;
        unique case (sel_nx)
            2'd0: begin
                if (x_nx < BAR1) begin
                    index_nx = 8'hff;
                end else if (x_nx < BAR2) begin
                    index_nx = 8'ha0;
                end else begin
                    index_nx = 8'h6c;
                end
            end
            2'd1: index_nx = addr_nx[7:0];
            2'd2: index_nx = SOLID_INDEX;
            default: begin
`ifdef FB_FILL_CHECKER_EN
                index_nx = (x_nx[4] ^ y_nx[4]) ? 8'hff : 8'h00;
`else
                index_nx = SOLID_INDEX;
`endif
            end
        endcase
    end

    // Write port, position counters and status; data moves with address.
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            write       <= 1'b0;
            oAddress    <= '0;
            writedata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
            sel_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
        end else if (launch) begin
            write     <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            sel_q     <= sel_nx;
            x_q       <= x_nx;
            y_q       <= y_nx;
            oAddress  <= addr_nx;
            writedata <= {{(DATA_W-8){1'b0}}, index_nx};
        end else if (last_beat) begin
            write       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            frame_count <= frame_count + 8'd1;
        end else if (accept) begin
            x_q       <= x_nx;
            y_q       <= y_nx;
            oAddress  <= addr_nx;
            writedata <= {{(DATA_W-8){1'b0}}, index_nx};
        end
    end

endmodule

// File: tb/tb_fb_fill_writer.sv
// tb_fb_fill_writer: scoreboard bench for fb_fill_writer.
// Uses a short frame (320x18) so every pattern row/column rule is exercised.
module tb_fb_fill_writer;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int W = 320;
    localparam int H = 18;
    localparam int N = W * H;

    logic          sdram_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    pattern_sel = 2'd0;
    logic          waitrequest = 1'b0;
    logic          write;
    logic [AW-1:0] oAddress;
    logic [DW-1:0] writedata;
    logic          busy;
    logic          done;
    logic [7:0]    frame_count;

    int checks = 0;
    int failures = 0;
    int wcyc = 0;
    int hold5 = 0;
    bit stall_mode = 1'b0;
    bit chk_done_nx = 1'b0;
    logic [63:0] sb_q[$];

    fb_fill_writer #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .FRAME_W(W),
        .FRAME_H(H),
        .SOLID_INDEX(8'hb9)
    ) dut (
        .sdram_clk(sdram_clk),
        .rst(rst),
        .start(start),
        .pattern_sel(pattern_sel),
        .waitrequest(waitrequest),
        .write(write),
        .oAddress(oAddress),
        .writedata(writedata),
        .busy(busy),
        .done(done),
        .frame_count(frame_count)
    );

    always #5 sdram_clk = ~sdram_clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input logic [1:0] sel,
                                             input int i);
        int x;
        int y;
        logic [7:0] idx;
        logic [31:0] iv;
        x = i % W;
        y = i / W;
        iv = i;
        case (sel)
            2'd0: idx = (x < 107) ? 8'hff : (x < 214) ? 8'ha0 : 8'h6c;
            2'd1: idx = iv[7:0];
            2'd2: idx = 8'hb9;
            default: begin
`ifdef FB_FILL_CHECKER_EN
                idx = (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 8'hff : 8'h00;
`else
                idx = 8'hb9;
`endif
            end
        endcase
        return {23'd0, iv[AW-1:0], 8'h00, idx};
    endfunction

    // Monitor: sample away from the active edge, pop on each accepted beat.
    always @(negedge sdram_clk) begin
        if (!rst) begin
            if (chk_done_nx) begin
                check("done_rise", {63'd0, done}, 64'd1);
                check("write_fall", {63'd0, write}, 64'd0);
                check("busy_fall", {63'd0, busy}, 64'd0);
                chk_done_nx = 1'b0;
            end
            if (write) wcyc++;
            if (stall_mode && write && oAddress == 25'd5) begin
                hold5++;
                check("stall_data", {48'd0, writedata}, 64'h0005);
            end
            if (write && !waitrequest) begin
                if (sb_q.size() == 0) begin
                    check("sb_extra_beat", {39'd0, oAddress}, 64'hffff_ffff);
                end else begin
                    check("beat", {23'd0, oAddress, writedata},
                          sb_q.pop_front());
                    if (sb_q.size() == 0) chk_done_nx = 1'b1;
                end
            end
        end
    end

    task automatic pulse_start(input logic [1:0] sel);
        for (int i = 0; i < N; i++) sb_q.push_back(exp_word(sel, i));
        wcyc = 0;
        pattern_sel = sel;
        start = 1'b1;
        @(posedge sdram_clk);
        #1;
        start = 1'b0;
        pattern_sel = ~sel;
        check("first_write", {63'd0, write}, 64'd1);
        check("first_addr", {39'd0, oAddress}, 64'd0);
        check("busy_on", {63'd0, busy}, 64'd1);
        check("done_clr", {63'd0, done}, 64'd0);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge sdram_clk);
            #1;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic wait_addr(input int a, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (write && oAddress == AW'(a)) begin
                seen = 1'b1;
                break;
            end
            @(posedge sdram_clk);
            #1;
        end
        check("addr_reached", {63'd0, seen}, 64'd1);
    endtask

    initial begin
        repeat (2) @(posedge sdram_clk);
        #1;
        check("rst_write", {63'd0, write}, 64'd0);
        check("rst_addr", {39'd0, oAddress}, 64'd0);
        check("rst_data", {48'd0, writedata}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_fcnt", {56'd0, frame_count}, 64'd0);
        rst = 1'b0;
        @(posedge sdram_clk);
        #1;

        // Solid fill, no stall.
        pulse_start(2'd2);
        wait_done(N + 20);
        check("solid_wcyc", 64'(wcyc), 64'(N));
        check("solid_fcnt", {56'd0, frame_count}, 64'd1);
        check("solid_sb_empty", 64'(sb_q.size()), 64'd0);

        // Bars fill from DONE, with an ignored start mid-fill.
        pulse_start(2'd0);
        repeat (100) @(posedge sdram_clk);
        #1;
        start = 1'b1;
        @(posedge sdram_clk);
        #1;
        start = 1'b0;
        check("busy_mid", {63'd0, busy}, 64'd1);
        wait_done(N + 20);
        check("bars_wcyc", 64'(wcyc), 64'(N));
        check("bars_fcnt", {56'd0, frame_count}, 64'd2);
        check("bars_sb_empty", 64'(sb_q.size()), 64'd0);

        // Ramp fill with a 3-cycle stall at address 5.
        hold5 = 0;
        stall_mode = 1'b1;
        pulse_start(2'd1);
        wait_addr(5, 50);
        waitrequest = 1'b1;
        repeat (3) @(posedge sdram_clk);
        #1;
        waitrequest = 1'b0;
        wait_done(N + 20);
        stall_mode = 1'b0;
        check("ramp_wcyc", 64'(wcyc), 64'(N + 3));
        check("ramp_hold5", 64'(hold5), 64'd4);
        check("ramp_fcnt", {56'd0, frame_count}, 64'd3);
        check("ramp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset mid-fill at address 1000.
        pulse_start(2'd3);
        wait_addr(1000, 1100);
        rst = 1'b1;
        @(posedge sdram_clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        check("abort_write", {63'd0, write}, 64'd0);
        check("abort_addr", {39'd0, oAddress}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_fcnt", {56'd0, frame_count}, 64'd0);
        @(posedge sdram_clk);
        #1;

        // Checker fill restarts from address 0.
        pulse_start(2'd3);
        wait_done(N + 20);
        check("chk_wcyc", 64'(wcyc), 64'(N));
        check("chk_fcnt", {56'd0, frame_count}, 64'd1);
        check("chk_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset and start together: reset wins.
        @(posedge sdram_clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge sdram_clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        check("rs_done", {63'd0, done}, 64'd0);
        check("rs_fcnt", {56'd0, frame_count}, 64'd0);
        @(posedge sdram_clk);
        #1;
        check("rs_write", {63'd0, write}, 64'd0);
        check("rs_busy", {63'd0, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
